alu_seq: RTL and testbench

Parametrised, clocked successor to the 4-bit combinational ALU: unsigned/two's-complement arithmetic, logic and barrel shifts on WIDTH-bit operands with registered NZCV flags. Operations are launched with a start/ready/done handshake; add/sub/logic/shift finish in one cycle, multiply and divide run iteratively over WIDTH cycles. Sits between the operand/op input registers of the lab datapath and the seven-segment display stage, which samples `result` on `done`.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_muldiv_iter.sv | 103 ++++++++++
 rtl/alu_seq.sv | 190 +++++++++++++++++++
 tb/tb_alu_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_pkg                                                       |
// | Purpose  : Shared types for the sequential ALU: opcode enum, NZCV flag   |
// |            struct, controller state enum and a signed-overflow helper.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_MUL = 4'b0011,
    OP_DIV = 4'b0100,
    OP_AND = 4'b0101,
    OP_OR  = 4'b0110,
    OP_XOR = 4'b0111,
    OP_SHL = 4'b1000,
    OP_SHR = 4'b1001
  } op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Two's-complement overflow from operand and result sign bits.
  // Subtraction overflows like an addition of the inverted subtrahend.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb, input logic is_sub);
    logic b_eff;
    b_eff = is_sub ? ~b_msb : b_msb;
    return (a_msb == b_eff) && (r_msb != a_msb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_muldiv_iter                                               |
// | Purpose  : Iterative unsigned shift-add multiplier / restoring divider,  |
// |            one step per cycle, WIDTH steps per operation.                |
// | Ports    : clk, rst_n (async, active low)                                |
// |            start   - load operands (a, b) and begin; is_div selects DIV   |
// |            last    - the current cycle performs the final step           |
// |            res     - value after the current step (valid with last)      |
// |            ovf     - MUL: high half nonzero; DIV: divide by zero         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module alu_muldiv_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  // hi_q: product high half (MUL) or partial remainder (DIV)
  // lo_q: multiplier shifting out (MUL) or dividend shifting into quotient (DIV)
  logic             busy_q, busy_d;
  logic             is_div_q, is_div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_neg;
  logic [WIDTH-1:0] hi_next, lo_next;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_neg   = div_shift < {1'b0, opnd_q};
    if (is_div_q) begin
      // Remainder always ends below the divisor, so the low WIDTH bits of the
      // trial subtraction are exact when it is kept.
      hi_next = div_neg ? div_shift[WIDTH-1:0] : (div_shift[WIDTH-1:0] - opnd_q);
      lo_next = {lo_q[WIDTH-2:0], ~div_neg};
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    busy_d   = busy_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    if (start) begin
      busy_d   = 1'b1;
      is_div_d = is_div;
      cnt_d    = CW'(WIDTH - 1);
      hi_d     = '0;
      lo_d     = is_div ? a : b;
      opnd_d   = is_div ? b : a;
    end else if (busy_q) begin
      hi_d   = hi_next;
      lo_d   = lo_next;
      cnt_d  = cnt_q - 1'b1;
      busy_d = (cnt_q != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
    end
  end

  assign last = busy_q && (cnt_q == '0);
  assign res  = lo_next;
  assign ovf  = is_div_q ? (opnd_q == '0) : (hi_next != '0);

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_seq                                                       |
// | Purpose  : Sequential WIDTH-bit ALU with start/ready/done handshake and  |
// |            registered NZCV flags.                                        |
// | Ports    : clk, rst_n (async, active low)                                |
// |            start/op/a/b  - launch request and operands (taken when ready)|
// |            ready         - idle, start will be accepted                  |
// |            done          - one-cycle pulse, result/flags valid           |
// |            result, n/z/c/v_flag - held until the next done               |
// | Config   : ALU_SEQ_MULDIV_EN enables iterative MUL/DIV; without it       |
// |            opcodes MUL/DIV behave as invalid opcodes.                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             n_flag,
  output logic             z_flag,
  output logic             c_flag,
  output logic             v_flag
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;

  logic             is_md_op;
  logic             md_start;
  logic             md_last;
  logic [WIDTH-1:0] md_res;
  logic             md_ovf;

`ifdef ALU_SEQ_MULDIV_EN
  assign is_md_op = (op == OP_MUL) || (op == OP_DIV);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (op == OP_DIV),
    .a      (a),
    .b      (b),
    .last   (md_last),
    .res    (md_res),
    .ovf    (md_ovf)
  );
`else
  assign is_md_op = 1'b0;
  assign md_last  = 1'b0;
  assign md_res   = '0;
  assign md_ovf   = 1'b0;
`endif

  // Single-cycle datapath, evaluated from the captured operands in EXEC.
  logic [WIDTH:0]   sum_w, diff_w, shl_w, shr_w;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] ex_res;
  logic             ex_c, ex_v, ex_valid;
  flags_t           ex_flags;

  always_comb begin
    shamt  = b_q[SHW-1:0];
    sum_w  = {1'b0, a_q} + {1'b0, b_q};
    diff_w = {1'b0, a_q} - {1'b0, b_q};
    // One guard bit beyond the operand catches the last bit shifted out;
    // a zero shift leaves the guard clear.
    shl_w  = {1'b0, a_q} << shamt;
    shr_w  = {a_q, 1'b0} >> shamt;
    ex_res   = '0;
    ex_c     = 1'b0;
    ex_v     = 1'b0;
    ex_valid = 1'b1;
    case (op_q)
      OP_ADD: begin
        ex_res = sum_w[WIDTH-1:0];
        ex_c   = sum_w[WIDTH];
        ex_v   = signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], sum_w[WIDTH-1], 1'b0);
      end
      OP_SUB: begin
        ex_res = diff_w[WIDTH-1:0];
        ex_c   = diff_w[WIDTH];
        ex_v   = signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], diff_w[WIDTH-1], 1'b1);
      end
      OP_AND: ex_res = a_q & b_q;
      OP_OR:  ex_res = a_q | b_q;
      OP_XOR: ex_res = a_q ^ b_q;
      OP_SHL: begin
        ex_res = shl_w[WIDTH-1:0];
        ex_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        ex_res = shr_w[WIDTH:1];
        ex_c   = shr_w[0];
      end
      default: ex_valid = 1'b0;
    endcase
    ex_flags.n = ex_valid & ex_res[WIDTH-1];
    ex_flags.z = ex_valid & (ex_res == '0);
    ex_flags.c = ex_c;
    ex_flags.v = ex_v;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    flags_d  = flags_q;
    md_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d = op;
          a_d  = a;
          b_d  = b;
          if (is_md_op) begin
            md_start = 1'b1;
            state_d  = ST_ITER;
          end else begin
            state_d  = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        result_d = ex_res;
        flags_d  = ex_flags;
        state_d  = ST_DONE;
      end
      ST_ITER: begin
        // Unreachable without the iterative unit; md_last is then tied low.
        if (md_last) begin
          result_d   = md_res;
          flags_d.n  = md_res[WIDTH-1];
          flags_d.z  = (md_res == '0);
          flags_d.c  = 1'b0;
          flags_d.v  = md_ovf;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign ready  = (state_q == ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign n_flag = flags_q.n;
  assign z_flag = flags_q.z;
  assign c_flag = flags_q.c;
  assign v_flag = flags_q.v;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_seq                                                    |
// | Purpose  : Scoreboard bench for alu_seq (WIDTH=8). Directed vectors push |
// |            expected result/flags/latency; a monitor pops on done.        |
// | Config   : MUL/DIV expectations follow ALU_SEQ_MULDIV_EN.                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = 4'h0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, done, n_flag, z_flag, c_flag, v_flag;
  logic [W-1:0] result;

  alu_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .result (result),
    .n_flag (n_flag),
    .z_flag (z_flag),
    .c_flag (c_flag),
    .v_flag (v_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   fl;
    int           issue;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef ALU_SEQ_MULDIV_EN
  localparam int LMD = W + 1;
`else
  localparam int LMD = 2;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("flags_nzcv", 32'({n_flag, z_flag, c_flag, v_flag}), 32'(e.fl));
          chk("latency", 32'(cyc - e.issue), 32'(e.lat));
        end
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Launch one op; operands are scrambled right after acceptance so any
  // late sampling shows up as a wrong result.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] er, input logic [3:0] ef, input int lat,
                       input bit push);
    exp_t e;
    wait_ready();
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (push) begin
      e.res = er; e.fl = ef; e.issue = cyc; e.lat = lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a     = ~x;
    b     = ~y;
    op    = 4'hF;
  endtask

  task automatic run(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] er, input logic [3:0] ef, input int lat);
    issue(o, x, y, er, ef, lat, 1'b1);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({n_flag, z_flag, c_flag, v_flag}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle ops            op     a      b      result flags(NZCV) lat
    run(4'b0001, 8'h7F, 8'h01, 8'h80, 4'b1001, 2);
    run(4'b0001, 8'hFF, 8'h01, 8'h00, 4'b0110, 2);
    run(4'b0010, 8'h03, 8'h05, 8'hFE, 4'b1010, 2);
    run(4'b0010, 8'h42, 8'h42, 8'h00, 4'b0100, 2);
    run(4'b0010, 8'h80, 8'h01, 8'h7F, 4'b0001, 2);
    run(4'b0101, 8'hF0, 8'h3C, 8'h30, 4'b0000, 2);
    run(4'b0110, 8'h0F, 8'h80, 8'h8F, 4'b1000, 2);
    run(4'b0111, 8'hAA, 8'hAA, 8'h00, 4'b0100, 2);
    run(4'b1000, 8'h81, 8'h01, 8'h02, 4'b0010, 2);
    run(4'b1000, 8'h21, 8'hF3, 8'h08, 4'b0010, 2);
    run(4'b1001, 8'h81, 8'h00, 8'h81, 4'b1000, 2);
    run(4'b1001, 8'h84, 8'h0B, 8'h10, 4'b0010, 2);
    run(4'b1111, 8'hFF, 8'hFF, 8'h00, 4'b0000, 2);
    run(4'b0000, 8'h12, 8'h34, 8'h00, 4'b0000, 2);

`ifdef ALU_SEQ_MULDIV_EN
    // MUL with stray starts during ITER: all must be ignored, ready low.
    issue(4'b0011, 8'h10, 8'h20, 8'h00, 4'b0101, LMD, 1'b1);
    for (int i = 0; i < W - 1; i++) begin
      start = 1'b1; op = 4'b0001; a = 8'h01; b = 8'h01;
      chk("ready_low_iter", 32'(ready), 32'd0);
      @(negedge clk);
    end
    start = 1'b0;
    wait_drain();
    run(4'b0011, 8'h0D, 8'h0B, 8'h8F, 4'b1000, LMD);
    run(4'b0100, 8'hC8, 8'h07, 8'h1C, 4'b0000, LMD);
    run(4'b0100, 8'h55, 8'h00, 8'hFF, 4'b1001, LMD);
    run(4'b0100, 8'h05, 8'h09, 8'h00, 4'b0100, LMD);
`else
    run(4'b0011, 8'h10, 8'h20, 8'h00, 4'b0000, LMD);
    run(4'b0100, 8'hC8, 8'h07, 8'h00, 4'b0000, LMD);
`endif

    // Abort an op in flight with reset; no done may follow.
    run(4'b0001, 8'h7F, 8'h01, 8'h80, 4'b1001, 2);
`ifdef ALU_SEQ_MULDIV_EN
    issue(4'b0011, 8'h0D, 8'h0B, 8'h00, 4'b0000, 0, 1'b0);
    repeat (3) @(negedge clk);
`else
    issue(4'b0001, 8'h7F, 8'h01, 8'h00, 4'b0000, 0, 1'b0);
`endif
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_flags", 32'({n_flag, z_flag, c_flag, v_flag}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);

    // Normal operation after the abort
    run(4'b0010, 8'h03, 8'h05, 8'hFE, 4'b1010, 2);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
